// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: display-mode encoding and counter width helpers for the pattern LED controller
package led_ctrl_pkg;
   typedef enum logic [1:0] {
      MODE_COUNT = 2'b00,
      MODE_SHIFT = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_OFF   = 2'b11
   } mode_e;
   function automatic int div_w(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction
   function automatic int fill_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction
   function automatic int blink_w(input int ticks);
      return $clog2(ticks + 1);
   endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle strobe every DIV clocks, high while the divider sits at DIV-1
module tick_gen
   import led_ctrl_pkg::*;
#(
   parameter int DIV = 12_500_000
) (
   input  logic clk_125,
   input  logic rst,
   output logic tick
);
   localparam int W = div_w(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk_125 or posedge rst)
      if (rst) r_cnt <= '0;
      else r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
   assign tick = (r_cnt == LAST);
endmodule

// File: rtl/pattern_led_ctrl.sv
// pattern_led_ctrl: samples serial data on each tick, detects a programmable pattern
// and shows the match count, shift register or a blink timer on the LEDs
module pattern_led_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int DIV         = 12_500_000,
   parameter int PAT_W       = 4,
   parameter int LED_W       = 4,
   parameter int BLINK_TICKS = 5
) (
   input  logic             clk_125,
   input  logic             rst,
   input  logic             data_in,
   input  logic [PAT_W-1:0] pattern,
   input  logic [1:0]       mode,
   output logic [LED_W-1:0] led,
   output logic             match,
   output logic             tick
);
   localparam int FW = fill_w(PAT_W);
   localparam int BW = blink_w(BLINK_TICKS);
   localparam logic [FW-1:0] FULL       = FW'(PAT_W);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_TICKS);
   logic             w_tick;
   logic [PAT_W-1:0] r_sr, w_sr_next;
   logic [FW-1:0]    r_fill, w_fill_next;
   logic [LED_W-1:0] r_match_cnt, r_led, w_led_next;
   logic [BW-1:0]    r_blink;
   logic             r_match;
   tick_gen #(.DIV(DIV)) u_tick (
      .clk_125(clk_125),
      .rst    (rst),
      .tick   (w_tick)
   );
   assign w_sr_next   = {r_sr[PAT_W-2:0], data_in};
   assign w_fill_next = (r_fill == FULL) ? FULL : r_fill + 1'b1;
   // the size cast both truncates and zero-extends the shift register to the LED width
   always_comb
      w_led_next = (mode_e'(mode) == MODE_COUNT) ? r_match_cnt :
                   (mode_e'(mode) == MODE_SHIFT) ? LED_W'(r_sr) :
                   (mode_e'(mode) == MODE_BLINK) ? {LED_W{r_blink != '0}} : '0;
   always_ff @(posedge clk_125 or posedge rst)
      if (rst) begin
         r_sr        <= '0;
         r_fill      <= '0;
         r_match     <= 1'b0;
         r_match_cnt <= '0;
         r_blink     <= '0;
         r_led       <= '0;
      end else begin
         if (w_tick) begin
            r_sr   <= w_sr_next;
            r_fill <= w_fill_next;
         end
         r_match     <= w_tick && (w_fill_next == FULL) && (w_sr_next == pattern);
         r_match_cnt <= r_match_cnt + LED_W'(r_match);
         if (r_match) r_blink <= BLINK_LOAD;
         else if (w_tick && r_blink != '0) r_blink <= r_blink - 1'b1;
         r_led <= w_led_next;
      end
   assign led   = r_led;
   assign match = r_match;
   assign tick  = w_tick;
endmodule

// File: doc/pattern_led_ctrl.md
# pattern_led_ctrl

Parametrised serial-pattern LED controller: the next generation of the divider → data source → LED controller chain on the Zybo board. It replaces the separate slow derived clock with an internal clock-enable tick in the `clk_125` domain. A serial data bit is sampled on each tick into a shift register and compared against a runtime-programmable pattern of width `PAT_W`. Matches are counted and shown on `LED_W` LEDs in one of four display modes selected at runtime.

## Interface
Parameters:
- `DIV`, 12_500_000: `clk_125` cycles per sample tick; legal range ≥ 2 (default gives 10 Hz).
- `PAT_W`, 4: pattern and shift-register width; legal range ≥ 2.
- `LED_W`, 4: LED count and match-counter width; legal range ≥ 1.
- `BLINK_TICKS`, 5: ticks the LEDs stay lit after a match in blink mode; legal range ≥ 1.

Ports:
- `clk_125`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `data_in`, in, 1: serial data bit, sampled only on tick edges; synchronous to `clk_125`.
- `pattern`, in, `PAT_W`: pattern to detect. MSB is the oldest bit. Read live at each tick.
- `mode`, in, 2: display mode. 00 = COUNT, 01 = SHIFT, 10 = BLINK, 11 = OFF.
- `led`, out, `LED_W`: registered LED drive.
- `match`, out, 1: one-cycle pulse per detected pattern.
- `tick`, out, 1: one-cycle sample strobe, exported for the ILA.

## Operation
- **Tick generation**
  - `div_cnt` counts 0 … `DIV-1` and then wraps to 0.
  - `tick` = (`div_cnt` == `DIV-1`), combinational from the register.
- **Sampling.** On each tick edge:
  - `sr` ← {`sr[PAT_W-2:0]`, `data_in`}.
  - `fill` increments and saturates at `PAT_W`.
- **Detection**
  - At the same tick edge, `match` is registered high iff:
    - the post-shift `fill` equals `PAT_W`, and
    - the post-shift `sr` == `pattern`.
  - Overlapping matches count. Example: pattern 1010 on stream 1010 10 gives two matches.
  - Before `PAT_W` samples have been taken, no match is possible, even if `pattern` is all zero.
- **Match counter**
  - `match_cnt` (`LED_W` bits) increments on every cycle that `match` is high.
  - It wraps modulo 2^`LED_W`; no saturation.
- **Blink timer**
  - A match loads `blink` with `BLINK_TICKS`. This re-arms the timer if it is already running.
  - Otherwise, each tick with `blink` > 0 decrements it.
  - If a match and a decrement coincide, the load wins.
- **LED mux** (registered every clock):
  - COUNT: `led` = `match_cnt`.
  - SHIFT: `led` = low `LED_W` bits of `sr`, zero-extended if `PAT_W` < `LED_W`.
  - BLINK: `led` = all ones while `blink` > 0, else 0.
  - OFF: `led` = 0.
- Counters, the shift register and the timer run in every mode; `mode` selects only the display.
- **Reset** (asynchronous, any time, including mid-pattern): clears `div_cnt`, `sr`, `fill`, `match`, `match_cnt`, `blink` and `led` to 0.
- Outputs at reset: `led` = 0, `match` = 0, `tick` = 0.

## Timing
- **First tick:** after `rst` deasserts, the first tick occurs in cycle `DIV-1`. Counting starts at cycle 0, the first rising edge with reset low.
- **Tick spacing:** ticks are exactly `DIV` cycles apart.
- Let E be the tick edge at which the completing bit is sampled:
  - `match` is high in the cycle after E.
  - `match_cnt` updates at E+1.
  - `led` shows the new count after E+2.
- **Blink latency:** in BLINK mode, `led` goes all-ones after E+2. It clears on the clock after the tick that decrements `blink` to 0, i.e. `BLINK_TICKS` ticks later.
- **Mode change:** a change of `mode` is reflected on `led` one clock later.
- **Pattern change:** a change of `pattern` is used from the next tick.
- **Throughput:** one sample per tick; no back-pressure.

## Structure
- **Package `led_ctrl_pkg`:**
  - mode encoding as a 2-bit enum: `MODE_COUNT`, `MODE_SHIFT`, `MODE_BLINK`, `MODE_OFF`;
  - `$clog2`-based width helpers for `div_cnt`, `fill` and `blink`.
- **Sub-module `tick_gen`:**
  - parameter `DIV`;
  - ports `clk_125`, `rst`, `tick`;
  - reusable for other board-rate strobes.
- **Top level:** the shift register, detector, counter, timer and LED mux stay in `pattern_led_ctrl`.

## Test plan
Unless stated otherwise, tests use `DIV`=4, `PAT_W`=4, `LED_W`=4, `BLINK_TICKS`=3.
1. **Tick spacing.** Release reset and run 20 cycles → `tick` is high on cycles 3, 7, 11, 15, 19 only; `led` = 0 throughout.
2. **Overlap detection.** `pattern`=1010, mode COUNT, feed 1,0,1,0,1,0 on successive ticks → `match` pulses after the 4th and 6th ticks; `led` = 0010.
3. **Counter wrap.** `pattern`=1111, feed 19 ones → 16 matches; `led` wraps to 0000.
4. **Blink re-arm.** Mode BLINK, one match followed by a second match 2 ticks later → `led` = 1111 continuously until 3 ticks after the second match, then 0000.
5. **Reset mid-pattern.** Feed 1,0,1, assert `rst` for 2 cycles, then feed 0 → no match, `led` = 0 (`fill` is cleared). Then feed 1,0,1,0 → a single match.
6. **Display modes.** Mode SHIFT after feeding 1,1,0,1 → `led` = 1101. Switch to mode OFF → `led` = 0000 one clock later, while `match_cnt` keeps counting.
